// File: rtl/tetris_pkg.sv
// Shared types and constants for the Tetris game logic.
package tetris_pkg;
  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    NORMAL = 2'd0,
    SOFT   = 2'd1,
    HARD   = 2'd2,
    PAUSED = 2'd3
  } drop_mode_t;

  localparam logic [7:0] HARD_KEY   = 8'h2c;
  localparam logic [7:0] SOFT_KEY   = 8'h16;
  localparam logic [2:0] LAND_STATE = 3'b010;
endpackage

// File: rtl/vsync_edge_sync.sv
// Two-flop synchroniser for an asynchronous vsync plus a
// registered rising-edge pulse, 3 Clk cycles after the rise.
module vsync_edge_sync (
  input  logic Clk,
  input  logic reset,
  input  logic vs,
  output logic frame_pulse
);
  logic s1, s2, s3;

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      s1          <= 1'b0;
      s2          <= 1'b0;
      s3          <= 1'b0;
      frame_pulse <= 1'b0;
    end else begin
      s1          <= vs;
      s2          <= s1;
      s3          <= s2;
      frame_pulse <= s2 & ~s3;
    end
  end
endmodule

// File: rtl/game_tick_gen.sv
// Gravity tick generator: frame-scaled normal/soft drop,
// fixed-rate hard drop and pause; one-cycle tick in Clk domain.
module game_tick_gen #(
  parameter int KEY_W = 8,
  parameter logic [KEY_W-1:0] HARD_KEY =
    KEY_W'(tetris_pkg::HARD_KEY),
  parameter logic [KEY_W-1:0] SOFT_KEY =
    KEY_W'(tetris_pkg::SOFT_KEY),
  parameter int STATE_W = 3,
  parameter logic [STATE_W-1:0] LAND_STATE =
    STATE_W'(tetris_pkg::LAND_STATE),
  parameter int LVL_W = 4,
  parameter int BASE_FRAMES = 48,
  parameter int FRAMES_PER_LVL = 3,
  parameter int MIN_FRAMES = 2,
  parameter int SOFT_FRAMES = 1,
  parameter int HARD_DIV = 4,
  parameter int CNT_W = $clog2(BASE_FRAMES + 1)
) (
  input  logic                          Clk,
  input  logic                          reset,
  input  logic                          VGA_VS,
  input  logic [KEY_W-1:0]              keycode,
  input  logic [STATE_W-1:0]            state,
  input  logic [LVL_W-1:0]              level,
  input  logic                          pause,
  output logic                          tick,
  output logic [tetris_pkg::MODE_W-1:0] mode,
  output logic [CNT_W-1:0]              frames_left
);
  import tetris_pkg::*;

  localparam int PW = CNT_W + LVL_W;
  localparam int HC_W =
    (HARD_DIV > 1) ? $clog2(HARD_DIV) : 1;
  localparam logic [HC_W-1:0] HC_LAST =
    HC_W'(HARD_DIV - 1);
  localparam logic signed [PW-1:0] MIN_S =
    PW'(MIN_FRAMES);
  localparam logic [CNT_W-1:0] MIN_P  = CNT_W'(MIN_FRAMES);
  localparam logic [CNT_W-1:0] SOFT_P = CNT_W'(SOFT_FRAMES);
  localparam logic [CNT_W-1:0] BASE_P = CNT_W'(BASE_FRAMES);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  drop_mode_t         mode_q, mode_d;
  drop_mode_t         shadow_q, shadow_d;
  logic [CNT_W-1:0]   fl_q, fl_d, fl_c;
  logic [CNT_W-1:0]   per, norm_p;
  logic [HC_W-1:0]    hc_q, hc_d;
  logic               ready_q, ready_d;
  logic               tick_q, tick_d;
  logic               frame_pulse;
  logic               land, hard_go;
  logic signed [PW-1:0] raw;

  vsync_edge_sync u_vs (
    .Clk         (Clk),
    .reset       (reset),
    .vs          (VGA_VS),
    .frame_pulse (frame_pulse)
  );

  // Wide signed intermediate so high levels clamp, not wrap.
  assign raw = PW'(BASE_FRAMES)
             - PW'(level) * PW'(FRAMES_PER_LVL);
  assign norm_p = (raw < MIN_S) ? MIN_P : raw[CNT_W-1:0];

  assign land = (mode_q == HARD)
             && (state == LAND_STATE);
  assign hard_go = (mode_q != PAUSED)
                && (keycode == HARD_KEY)
                && ready_q
                && (state != LAND_STATE);

  always_comb begin
    mode_d   = mode_q;
    shadow_d = shadow_q;
    fl_d     = fl_q;
    fl_c     = fl_q;
    hc_d     = hc_q;
    tick_d   = 1'b0;
    per      = norm_p;
    ready_d  = (keycode != HARD_KEY) ? 1'b1 : ready_q;

    if (pause) begin
      mode_d = PAUSED;
      if (mode_q != PAUSED) shadow_d = mode_q;
    end else if (land) begin
      mode_d = NORMAL;
      fl_d   = norm_p;
    end else if (hard_go) begin
      mode_d  = HARD;
      hc_d    = '0;
      ready_d = 1'b0;
    end else begin
      if (mode_q == PAUSED)
        mode_d = shadow_q;
      else if (mode_q != HARD)
        mode_d = (keycode == SOFT_KEY) ? SOFT : NORMAL;

      per  = (mode_d == SOFT) ? SOFT_P : norm_p;
      fl_c = (fl_q > per) ? per : fl_q;

      if (mode_d == HARD) begin
        tick_d = (hc_q == HC_LAST);
        hc_d   = tick_d ? '0 : hc_q + HC_W'(1);
      end else begin
        fl_d = fl_c;
        if (frame_pulse) begin
          if (fl_c <= ONE) begin
            tick_d = 1'b1;
            fl_d   = per;
          end else begin
            fl_d = fl_c - ONE;
          end
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      mode_q   <= NORMAL;
      shadow_q <= NORMAL;
      fl_q     <= BASE_P;
      hc_q     <= '0;
      ready_q  <= 1'b1;
      tick_q   <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      shadow_q <= shadow_d;
      fl_q     <= fl_d;
      hc_q     <= hc_d;
      ready_q  <= ready_d;
      tick_q   <= tick_d;
    end
  end

  assign tick        = tick_q;
  assign mode        = mode_q;
  assign frames_left = fl_q;
endmodule
